mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/wait_timer.sv | 45 ++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_arbiter_pkg: shared state encoding, port IDs and grant helper.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_CPU = 2'd1,
    SERVE_DBG = 2'd2,
    DONE      = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // On a tie the port that was not granted last time wins.
  function automatic logic next_grant(input logic cpu_req, input logic dbg_req,
                                      input logic last_grant);
    logic grant;
    grant = PORT_CPU;
    if (cpu_req && dbg_req) begin
      grant = ~last_grant;
    end else if (dbg_req) begin
      grant = PORT_DBG;
    end
    return grant;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | mem_arbiter_if: core port, debug port and unified memory bus signals.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_adr;
  logic [WIDTH-1:0] cpu_wd;
  logic [WIDTH-1:0] cpu_rd;
  logic             cpu_ack;
  logic             cpu_err;

  logic             dbg_req;
  logic             dbg_we;
  logic [WIDTH-1:0] dbg_adr;
  logic [WIDTH-1:0] dbg_wd;
  logic [WIDTH-1:0] dbg_rd;
  logic             dbg_ack;
  logic             dbg_err;

  logic             mem_we;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd;
  logic             mem_ready;

  logic             busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wd,
    output cpu_rd, cpu_ack, cpu_err,
    input  dbg_req, dbg_we, dbg_adr, dbg_wd,
    output dbg_rd, dbg_ack, dbg_err,
    output mem_we, mem_adr, mem_wd,
    input  mem_rd, mem_ready,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wd,
    input  cpu_rd, cpu_ack, cpu_err,
    output dbg_req, dbg_we, dbg_adr, dbg_wd,
    input  dbg_rd, dbg_ack, dbg_err,
    input  mem_we, mem_adr, mem_wd,
    output mem_rd, mem_ready,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/wait_timer.sv
// +--------------------------------------------------------------------------+
// | wait_timer: memory wait-cycle counter; expired on the last allowed cycle.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module wait_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  localparam logic [CW-1:0] c_one = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + c_one;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == (limit - c_one));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | mem_arbiter: two-port (core / debug loader) arbiter onto one memory bus. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  import mem_arbiter_pkg::*;

  localparam logic [7:0] c_wait_limit = 8'(MAX_WAIT);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] cpu_rd_q, cpu_rd_d;
  logic [WIDTH-1:0] dbg_rd_q, dbg_rd_d;
  logic             cpu_err_q, cpu_err_d;
  logic             dbg_err_q, dbg_err_d;

  logic             sel_dbg;
  logic             serving;
  logic             cur_req;
  logic             cur_we;
  logic [WIDTH-1:0] cur_adr;
  logic [WIDTH-1:0] cur_wd;
  logic             timer_clear;
  logic             timer_enable;
  logic             timer_expired;

  assign sel_dbg = (state_q == SERVE_DBG);
  assign serving = (state_q == SERVE_CPU) || sel_dbg;
  assign cur_req = sel_dbg ? bus.dbg_req : bus.cpu_req;
  assign cur_we  = sel_dbg ? bus.dbg_we  : bus.cpu_we;
  assign cur_adr = sel_dbg ? bus.dbg_adr : bus.cpu_adr;
  assign cur_wd  = sel_dbg ? bus.dbg_wd  : bus.cpu_wd;

  // Held clear through IDLE so every SERVE starts counting from zero.
  assign timer_clear  = (state_q == IDLE);
  assign timer_enable = serving && cur_req && !bus.mem_ready;

  wait_timer #(
    .CW(8)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .limit   (c_wait_limit),
    .expired (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cpu_rd_d     = cpu_rd_q;
    dbg_rd_d     = dbg_rd_q;
    cpu_err_d    = cpu_err_q;
    dbg_err_d    = dbg_err_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          last_grant_d = next_grant(bus.cpu_req, bus.dbg_req, last_grant_q);
          state_d      = (last_grant_d == PORT_DBG) ? SERVE_DBG : SERVE_CPU;
        end
      end
      SERVE_CPU, SERVE_DBG: begin
        if (!cur_req) begin
          // Requester gave up: leave results untouched and never ack.
          state_d = IDLE;
        end else if (bus.mem_ready) begin
          state_d = DONE;
          if (sel_dbg) begin
            if (!cur_we) dbg_rd_d = bus.mem_rd;
            dbg_err_d = 1'b0;
          end else begin
            if (!cur_we) cpu_rd_d = bus.mem_rd;
            cpu_err_d = 1'b0;
          end
        end else if (timer_expired) begin
          state_d = DONE;
          if (sel_dbg) dbg_err_d = 1'b1;
          else         cpu_err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DBG;
      cpu_rd_q     <= '0;
      dbg_rd_q     <= '0;
      cpu_err_q    <= 1'b0;
      dbg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cpu_rd_q     <= cpu_rd_d;
      dbg_rd_q     <= dbg_rd_d;
      cpu_err_q    <= cpu_err_d;
      dbg_err_q    <= dbg_err_d;
    end
  end

  assign bus.mem_we  = serving && cur_we;
  assign bus.mem_adr = serving ? cur_adr : '0;
  assign bus.mem_wd  = serving ? cur_wd  : '0;

  assign bus.cpu_ack = (state_q == DONE) && (last_grant_q == PORT_CPU);
  assign bus.dbg_ack = (state_q == DONE) && (last_grant_q == PORT_DBG);
  assign bus.cpu_rd  = cpu_rd_q;
  assign bus.dbg_rd  = dbg_rd_q;
  assign bus.cpu_err = cpu_err_q;
  assign bus.dbg_err = dbg_err_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  import mem_arbiter_pkg::*;

  localparam int WIDTH    = 32;
  localparam int MAX_WAIT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mem_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mem_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] data;
    int          waits;
  } plan_t;

  typedef struct {
    logic        port;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    bit          use_port;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] data;
    int          waits;
  } req_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rd[2];
  logic        model_err[2];
  logic        model_last;
  bit          auto_mem = 1'b0;
  int          wait_tbl[9] = '{0, 0, 1, 2, 3, 5, 14, 15, 20};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    model_rd[0]  = '0;
    model_rd[1]  = '0;
    model_err[0] = 1'b0;
    model_err[1] = 1'b0;
    model_last   = PORT_DBG;
  endfunction

  function automatic int lat_of(input int waits);
    return (waits >= MAX_WAIT) ? MAX_WAIT + 1 : waits + 2;
  endfunction

  // Reference model: one served access, in grant order.
  task automatic plan_access(input logic port, input req_t r);
    plan_t p;
    exp_t  e;
    p.we = r.we; p.adr = r.adr; p.wd = r.wd; p.data = r.data; p.waits = r.waits;
    plan_q.push_back(p);
    if (r.waits >= MAX_WAIT) begin
      model_err[port] = 1'b1;
    end else begin
      model_err[port] = 1'b0;
      if (!r.we) model_rd[port] = r.data;
    end
    e.port = port; e.rd = model_rd[port]; e.err = model_err[port];
    exp_q.push_back(e);
    model_last = port;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.use_port = 1'b1;
    r.we       = 1'($urandom_range(0, 1));
    r.adr      = $urandom;
    r.wd       = $urandom;
    r.data     = $urandom;
    r.waits    = wait_tbl[$urandom_range(0, 8)];
    return r;
  endfunction

  // Memory responder: serves the planned accesses in order.
  logic  prev_serve = 1'b0;
  logic  in_serve;
  int    mcnt = 0;
  plan_t cur;
  always @(negedge clk) begin
    if (auto_mem) begin
      in_serve = bus.busy && !bus.cpu_ack && !bus.dbg_ack;
      if (in_serve && !prev_serve) begin
        if (plan_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem access: got unplanned access adr %h expected none", bus.mem_adr);
          cur.we = 1'b0; cur.adr = '0; cur.wd = '0; cur.data = '0; cur.waits = 1000;
        end else begin
          cur = plan_q.pop_front();
          chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
          chk("mem_adr", bus.mem_adr, cur.adr);
          chk("mem_wd", bus.mem_wd, cur.wd);
        end
        mcnt = 0;
      end
      if (in_serve) begin
        bus.mem_ready = (mcnt == cur.waits);
        bus.mem_rd    = bus.mem_ready ? cur.data : $urandom;
        mcnt++;
      end else begin
        bus.mem_ready = 1'b0;
      end
      prev_serve = in_serve;
    end else begin
      prev_serve = 1'b0;
    end
  end

  task automatic check_ack(input logic port, input logic [31:0] rd, input logic err);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL ack: got ack on port %0d expected no ack", port);
    end else begin
      e = exp_q.pop_front();
      chk("ack port", 32'(port), 32'(e.port));
      chk(port ? "dbg_rd" : "cpu_rd", rd, e.rd);
      chk(port ? "dbg_err" : "cpu_err", 32'(err), 32'(e.err));
    end
  endtask

  // Monitor: pops the scoreboard whenever an ack is presented.
  always @(negedge clk) begin
    if (bus.cpu_ack && bus.dbg_ack) begin
      bad++;
      $display("FAIL ack exclusivity: got both acks high expected at most one");
    end
    if (bus.mem_we && (!bus.busy || bus.cpu_ack || bus.dbg_ack)) begin
      bad++;
      $display("FAIL mem_we idle: got 1 expected 0 outside serve");
    end
    if (bus.cpu_ack) check_ack(PORT_CPU, bus.cpu_rd, bus.cpu_err);
    if (bus.dbg_ack) check_ack(PORT_DBG, bus.dbg_rd, bus.dbg_err);
  end

  task automatic run_round(input req_t c, input req_t d, input string tag,
                           output int we_cycles);
    bit   both;
    logic first;
    int   cyc, lat_c, lat_d, exp_c, exp_d;
    bit   c_done, d_done;
    both = c.use_port && d.use_port;
    if (both) first = (model_last == PORT_CPU) ? PORT_DBG : PORT_CPU;
    else      first = c.use_port ? PORT_CPU : PORT_DBG;
    if (first == PORT_CPU) begin
      plan_access(PORT_CPU, c);
      if (both) plan_access(PORT_DBG, d);
      exp_c = lat_of(c.waits);
      exp_d = exp_c + 1 + lat_of(d.waits);
    end else begin
      plan_access(PORT_DBG, d);
      if (both) plan_access(PORT_CPU, c);
      exp_d = lat_of(d.waits);
      exp_c = exp_d + 1 + lat_of(c.waits);
    end
    @(negedge clk);
    bus.cpu_req = c.use_port; bus.cpu_we = c.we; bus.cpu_adr = c.adr; bus.cpu_wd = c.wd;
    bus.dbg_req = d.use_port; bus.dbg_we = d.we; bus.dbg_adr = d.adr; bus.dbg_wd = d.wd;
    c_done = !c.use_port; d_done = !d.use_port;
    cyc = 0; lat_c = 0; lat_d = 0; we_cycles = 0;
    while (!(c_done && d_done) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_we) we_cycles++;
      if (!c_done && bus.cpu_ack) begin c_done = 1'b1; lat_c = cyc; bus.cpu_req = 1'b0; end
      if (!d_done && bus.dbg_ack) begin d_done = 1'b1; lat_d = cyc; bus.dbg_req = 1'b0; end
    end
    if (!(c_done && d_done)) begin
      total++; bad++;
      $display("FAIL %s ack timeout: got no ack in 400 cycles expected ack", tag);
      bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    end
    if (c.use_port) chk({tag, " cpu latency"}, 32'(lat_c), 32'(exp_c));
    if (d.use_port) chk({tag, " dbg latency"}, 32'(lat_d), 32'(exp_d));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    req_t none, c, d;
    int   wec;
    int   p;
    none.use_port = 1'b0; none.we = 1'b0; none.adr = '0; none.wd = '0;
    none.data = '0; none.waits = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_adr = '0; bus.cpu_wd = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_adr = '0; bus.dbg_wd = '0;
    bus.mem_rd = '0; bus.mem_ready = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset cpu_ack", 32'(bus.cpu_ack), 0);
    chk("reset dbg_ack", 32'(bus.dbg_ack), 0);
    chk("reset cpu_err", 32'(bus.cpu_err), 0);
    chk("reset dbg_err", 32'(bus.dbg_err), 0);
    chk("reset cpu_rd", bus.cpu_rd, 0);
    chk("reset dbg_rd", bus.dbg_rd, 0);
    chk("reset mem_we", 32'(bus.mem_we), 0);
    chk("reset mem_adr", bus.mem_adr, 0);
    reset = 1'b1;
    auto_mem = 1'b1;

    // First core read with zero-wait memory.
    c = none; c.use_port = 1'b1; c.adr = 32'h10; c.data = 32'hE3A00005;
    run_round(c, none, "first read", wec);

    // Simultaneous pairs after reset alternate winners.
    do_reset();
    c = none; c.use_port = 1'b1; c.adr = 32'h100; c.data = 32'h11111111;
    d = none; d.use_port = 1'b1; d.adr = 32'h200; d.data = 32'h22222222;
    run_round(c, d, "tie1", wec);
    c.data = 32'h33333333; d.data = 32'h44444444;
    run_round(c, d, "tie2", wec);

    // Debug write with three wait cycles.
    d = none; d.use_port = 1'b1; d.we = 1'b1; d.adr = 32'h20; d.wd = 32'hDEADBEEF;
    d.data = 32'h55555555; d.waits = 3;
    run_round(none, d, "dbg write", wec);
    chk("dbg write mem_we cycles", 32'(wec), 4);

    // Timeout, last-chance ready, and error clearing.
    c = none; c.use_port = 1'b1; c.adr = 32'h30; c.data = 32'h66666666; c.waits = 100;
    run_round(c, none, "timeout", wec);
    c.waits = MAX_WAIT - 1; c.data = 32'h77777777;
    run_round(c, none, "late ready", wec);
    c.waits = MAX_WAIT;
    run_round(c, none, "timeout edge", wec);
    c.waits = 0; c.data = 32'h88888888;
    run_round(c, none, "clear err", wec);

    // Requester withdraws before memory answers.
    auto_mem = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 32'h40;
    model_last = PORT_CPU;
    repeat (3) @(negedge clk);
    chk("abort busy before", 32'(bus.busy), 1);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("abort busy after", 32'(bus.busy), 0);
    chk("abort cpu_rd", bus.cpu_rd, model_rd[PORT_CPU]);
    repeat (2) @(negedge clk);

    // Reset in the middle of a core write.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_adr = 32'h44; bus.cpu_wd = 32'h12345678;
    repeat (2) @(negedge clk);
    chk("pre-reset mem_we", 32'(bus.mem_we), 1);
    #2 reset = 1'b0;
    #1;
    chk("async reset mem_we", 32'(bus.mem_we), 0);
    chk("async reset busy", 32'(bus.busy), 0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    auto_mem = 1'b1;
    c = none; c.use_port = 1'b1; c.adr = 32'h50; c.data = 32'h99999999; c.waits = 1;
    d = none; d.use_port = 1'b1; d.adr = 32'h60; d.data = 32'hAAAAAAAA; d.waits = 2;
    run_round(c, d, "post reset", wec);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(1, 3);
      c = rand_req(); c.use_port = p[0];
      d = rand_req(); d.use_port = p[1];
      run_round(c, d, "random", wec);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    chk("plan drained", 32'(plan_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
